inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 start  input  1  one-cycle load request, sampled only in IDLE.
REQ-004 length  input  7  number of 32-bit words to load, sampled with start; legal range 1..64.
REQ-005 abort  input  1  cancels an active load.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte-stream ready; a byte is accepted when in_valid and in_ready are both 1.
REQ-009 ram_we  output  1  instruction RAM write enable.
REQ-010 ram_addr  output  6  instruction RAM word address; matches the CPU fetch index PC[7:2].
REQ-011 ram_din  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the CPU in reset while a load is in progress.
REQ-013 done  output  1  one-cycle pulse at successful completion.
REQ-014 err  output  1  one-cycle pulse on an illegal length or an abort.
REQ-015 checksum  output  32  XOR of all words written in the current or last load.
REQ-016 words_loaded  output  7  count of words written in the current or last load.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WRITE and DONE; all outputs SHALL be Moore or registered.
REQ-018 In IDLE, a start with length 1..64 SHALL go to LOAD and SHALL clear the byte count, word address, checksum and words_loaded.
REQ-019 In IDLE, a start with length 0 or greater than 64 SHALL pulse err the next cycle, stay in IDLE, and leave checksum and words_loaded unchanged.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 LOAD: in_ready=1; each accepted byte SHALL shift in big-endian (first byte lands in [31:24], fourth in [7:0]); byte_cnt is 2 bits.
REQ-022 Acceptance of the 4th byte SHALL move to WRITE; in_ready SHALL be 0 in every state except LOAD.
REQ-023 WRITE lasts exactly one cycle: ram_we=1, ram_addr=word_addr, ram_din=assembled word.
REQ-024 In that WRITE cycle, checksum^=word and words_loaded+1 SHALL take effect at the next edge.
REQ-025 From WRITE, the FSM SHALL go to DONE if word_addr==length-1, else to LOAD with word_addr+1.
REQ-026 Latency from the 4th byte accepted to ram_we high SHALL be 1 cycle; max throughput is 1 word per 5 cycles.
REQ-027 DONE: done=1 for one cycle, then IDLE.
REQ-028 ram_we and done SHALL be 0 outside WRITE and DONE respectively.
REQ-029 cpu_hold SHALL be 1 in LOAD, WRITE and DONE, and 0 in IDLE.
REQ-030 abort in LOAD or WRITE SHALL go to IDLE next cycle with an err pulse; partial bytes are discarded.
REQ-031 abort coincident with WRITE SHALL win: ram_we forced 0, no checksum or count update.
REQ-032 abort in IDLE or DONE SHALL be ignored.
REQ-033 When length==64, word_addr reaching 63 SHALL end the load; word_addr SHALL never wrap to 0 within a load.
REQ-034 Gaps in in_valid SHALL only stall; the byte count is preserved across idle cycles.

Reset
REQ-035 rst=0 SHALL asynchronously force IDLE: in_ready=0, ram_we=0, ram_addr=0, ram_din=0, cpu_hold=0, done=0, err=0, checksum=0, words_loaded=0, and clear byte_cnt and word_addr.
REQ-036 Reset mid-load SHALL abandon the load without an err pulse; release is synchronous to the next clk edge.

Verification
REQ-037 Load length=1, bytes 8C,01,00,20 -> one ram_we with addr 0, din 8C010020; done 1 cycle later; checksum=8C010020; words_loaded=1.
REQ-038 Load length=2, words 00221820 and 00221822 -> addrs 0 then 1; checksum=00000002; cpu_hold high from the cycle after start to DONE inclusive.
REQ-039 start with length=0, then with length=65 -> err pulse each time; no ram_we; FSM stays IDLE.
REQ-040 Load length=3, abort after 5 bytes -> exactly 1 write (addr 0); err pulse; then a new start works normally from addr 0.
REQ-041 Load length=64 with random in_valid gaps -> 64 writes, addrs 0..63 in order, done once, checksum equals the reference XOR.
REQ-042 rst low during WRITE -> ram_we drops immediately; all outputs at reset values; no done or err.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the instruction loader.
`default_nettype none

interface inst_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_din;

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_din
  );
endinterface

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// inst_loader : assembles big-endian 32-bit words from a byte stream and
//               writes them to instruction RAM while holding the CPU in reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inst_loader (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         length,
  input  logic               abort,
  inst_loader_if.slave       bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [31:0]        checksum,
  output logic [6:0]         words_loaded
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [1:0]  byte_cnt;
  logic [5:0]  word_addr;
  logic [5:0]  len_m1;
  logic [31:0] word;
  logic        len_ok;
  logic        accept;
  logic        last_word;

  assign len_ok    = (length != 7'd0) && (length <= 7'd64);
  assign accept    = (state == LOAD) && bus.in_valid;
  // len_m1 is 6 bits so length 64 maps to 63 and word_addr never wraps.
  assign last_word = (word_addr == len_m1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && len_ok) state_nx = LOAD;
      LOAD: begin
        if (abort)                              state_nx = IDLE;
        else if (accept && (byte_cnt == 2'd3))  state_nx = WRITE;
      end
      WRITE: begin
        if (abort)          state_nx = IDLE;
        else if (last_word) state_nx = DONE;
        else                state_nx = LOAD;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ram_we alone looks at abort so an abort in WRITE suppresses the write.
  always_comb begin
    bus.in_ready = (state == LOAD);
    bus.ram_we   = (state == WRITE) && !abort;
    done         = (state == DONE);
    cpu_hold     = (state != IDLE);
  end

  assign bus.ram_addr = word_addr;
  assign bus.ram_din  = word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt     <= 2'd0;
      word_addr    <= 6'd0;
      len_m1       <= 6'd0;
      word         <= 32'd0;
      checksum     <= 32'd0;
      words_loaded <= 7'd0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              byte_cnt     <= 2'd0;
              word_addr    <= 6'd0;
              checksum     <= 32'd0;
              words_loaded <= 7'd0;
              len_m1       <= length[5:0] - 6'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            err      <= 1'b1;
            byte_cnt <= 2'd0;
          end else if (accept) begin
            word     <= {word[23:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (abort) begin
            err      <= 1'b1;
            byte_cnt <= 2'd0;
          end else begin
            checksum     <= checksum ^ word;
            words_loaded <= words_loaded + 7'd1;
            if (!last_word) word_addr <= word_addr + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: vector table of loads plus abort,
// long-load and reset corner sequences, with a write scoreboard.
`default_nettype none

module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  length;
  logic        abort;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [31:0] checksum;
  logic [6:0]  words_loaded;

  inst_loader_if bus ();

  inst_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .length       (length),
    .abort        (abort),
    .bus          (bus.slave),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .checksum     (checksum),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [6:0]       len;
    logic [3:0][31:0] w;
    logic             exp_err;
    logic [31:0]      exp_cks;
    logic [6:0]       exp_wl;
  } vec_t;

  wr_t  sbq[$];
  vec_t vt[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic prev_we = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_we) begin
        if (sbq.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          check("wr_addr", 64'(bus.ram_addr), 64'(e.addr));
          check("wr_data", 64'(bus.ram_din), 64'(e.data));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_we", 64'(prev_we), 64'd1);
      end
      if (err) err_cnt++;
      prev_we = bus.ram_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 3; i >= 0; i--)
      send_byte(w[i*8 +: 8], $urandom_range(gap_max, 0));
  endtask

  task automatic start_load(input logic [6:0] len);
    start  = 1'b1;
    length = len;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (cpu_hold && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 64'(cpu_hold), 64'd0);
    tick();
    tick();
  endtask

  function automatic vec_t mk(input logic [6:0] len, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input logic e,
                              input logic [31:0] cks, input logic [6:0] wl);
    vec_t v;
    v.len = len; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.exp_err = e; v.exp_cks = cks; v.exp_wl = wl;
    return v;
  endfunction

  initial begin
    int e0, d0;
    logic [31:0] ref_x, w;

    vt[0] = mk(7'd1,   32'h8C010020, 32'h0, 32'h0, 32'h0, 1'b0, 32'h8C010020, 7'd1);
    vt[1] = mk(7'd2,   32'h00221820, 32'h00221822, 32'h0, 32'h0, 1'b0, 32'h00000002, 7'd2);
    vt[2] = mk(7'd0,   32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h00000002, 7'd2);
    vt[3] = mk(7'd65,  32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h00000002, 7'd2);
    vt[4] = mk(7'd4,   32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888, 1'b0, 32'hFFFFFFFF, 7'd4);
    vt[5] = mk(7'd3,   32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'h0, 1'b0, 32'hCC99E897, 7'd3);
    vt[6] = mk(7'd127, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hCC99E897, 7'd3);

    rst = 1'b0; start = 1'b0; length = 7'd0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_ram_we",   64'(bus.ram_we), 64'd0);
    check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_ram_din",  64'(bus.ram_din), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    check("rst_words",    64'(words_loaded), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      e0 = err_cnt; d0 = done_cnt;
      start_load(vt[i].len);
      if (!vt[i].exp_err) begin
        check("hold_after_start", 64'(cpu_hold), 64'd1);
        for (int j = 0; j < int'(vt[i].len); j++) begin
          sbq.push_back('{addr: 6'(j), data: vt[i].w[j]});
          send_word(vt[i].w[j], j % 2);
        end
        wait_idle();
      end else begin
        check("err_pulse", 64'(err), 64'd1);
        check("idle_on_illegal", 64'(cpu_hold), 64'd0);
        tick();
        tick();
      end
      check("vec_err_count",  64'(err_cnt - e0), vt[i].exp_err ? 64'd1 : 64'd0);
      check("vec_done_count", 64'(done_cnt - d0), vt[i].exp_err ? 64'd0 : 64'd1);
      check("vec_checksum",   64'(checksum), 64'(vt[i].exp_cks));
      check("vec_words",      64'(words_loaded), 64'(vt[i].exp_wl));
      check("vec_sb_empty",   64'(sbq.size()), 64'd0);
    end

    // Abort in IDLE is ignored.
    e0 = err_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_err", 64'(err), 64'd0);
    check("idle_abort_hold", 64'(cpu_hold), 64'd0);

    // Length 3, abort after five bytes: one write, then restart from addr 0.
    e0 = err_cnt; d0 = done_cnt;
    start_load(7'd3);
    sbq.push_back('{addr: 6'd0, data: 32'hA1B2C3D4});
    send_word(32'hA1B2C3D4, 0);
    send_byte(8'h55, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_load_err", 64'(err), 64'd1);
    check("abort_load_hold", 64'(cpu_hold), 64'd0);
    tick();
    check("abort_load_errcnt", 64'(err_cnt - e0), 64'd1);
    check("abort_load_done", 64'(done_cnt - d0), 64'd0);
    check("abort_load_words", 64'(words_loaded), 64'd1);
    check("abort_load_cks", 64'(checksum), 64'hA1B2C3D4);
    d0 = done_cnt;
    start_load(7'd1);
    sbq.push_back('{addr: 6'd0, data: 32'h8C010020});
    send_word(32'h8C010020, 1);
    wait_idle();
    check("restart_done", 64'(done_cnt - d0), 64'd1);
    check("restart_cks", 64'(checksum), 64'h8C010020);
    check("restart_sb_empty", 64'(sbq.size()), 64'd0);

    // Abort coincident with WRITE suppresses the write and the update.
    e0 = err_cnt;
    start_load(7'd2);
    send_word(32'h0BADF00D, 0);
    abort = 1'b1;
    @(negedge clk);
    check("abort_wr_we", 64'(bus.ram_we), 64'd0);
    tick(); abort = 1'b0;
    check("abort_wr_hold", 64'(cpu_hold), 64'd0);
    tick();
    check("abort_wr_errcnt", 64'(err_cnt - e0), 64'd1);
    check("abort_wr_words", 64'(words_loaded), 64'd0);
    check("abort_wr_cks", 64'(checksum), 64'd0);

    // 64-word load with random gaps and a stray start mid-load.
    e0 = err_cnt; d0 = done_cnt; ref_x = 32'd0;
    start_load(7'd64);
    for (int j = 0; j < 64; j++) begin
      w = $urandom;
      ref_x ^= w;
      sbq.push_back('{addr: 6'(j), data: w});
      send_word(w, 2);
      if (j == 10) begin
        start_load(7'd1);
      end
    end
    wait_idle();
    check("long_done", 64'(done_cnt - d0), 64'd1);
    check("long_err", 64'(err_cnt - e0), 64'd0);
    check("long_cks", 64'(checksum), 64'(ref_x));
    check("long_words", 64'(words_loaded), 64'd64);
    check("long_sb_empty", 64'(sbq.size()), 64'd0);

    // Reset asserted during the second WRITE of a two-word load.
    start_load(7'd2);
    sbq.push_back('{addr: 6'd0, data: 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 0);
    send_word(32'h13572468, 0);
    e0 = err_cnt; d0 = done_cnt;
    rst = 1'b0;
    #1;
    check("rw_ram_we", 64'(bus.ram_we), 64'd0);
    check("rw_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("rw_ram_din", 64'(bus.ram_din), 64'd0);
    check("rw_hold", 64'(cpu_hold), 64'd0);
    check("rw_cks", 64'(checksum), 64'd0);
    check("rw_words", 64'(words_loaded), 64'd0);
    check("rw_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    check("rw_no_err", 64'(err_cnt - e0), 64'd0);
    check("rw_no_done", 64'(done_cnt - d0), 64'd0);
    check("rw_idle", 64'(cpu_hold), 64'd0);
    check("rw_sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
